alu_result_checker: RTL and testbench

Synthesizable, self-checking receiver for the 32-bit ALU's output interface. On each strobe it samples the operands, operation select and the ALU's res/zero outputs. It recomputes the expected result with an internal golden model and scores the result as pass or fail. It sits beside the ALU in the processor datapath and bench, and gives hardware-visible pass/fail counters plus a sticky capture of the first mismatch.

---
 rtl/alu_result_checker.sv | 116 +++++++++++
 tb/tb_alu_result_checker.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/alu_result_checker.sv
// Purpose: scores every ALU result strobe against a golden model; keeps saturating pass/fail counts and a sticky first-mismatch capture.
// Latency: a strobe sampled at edge N is scored at edge N+1 (chk_done and counters are visible after N+1).
// Backpressure: none, one check per cycle is accepted every cycle with no stall.
module alu_result_checker #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             chk_valid,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    input  logic [2:0]       sel,
    input  logic [31:0]      res,
    input  logic             zero,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err,
    output logic             chk_done,
    output logic [2:0]       ff_sel,
    output logic [31:0]      ff_a,
    output logic [31:0]      ff_b,
    output logic [31:0]      ff_res,
    output logic [31:0]      ff_exp
);

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  sel;
        logic [31:0] res;
        logic        zero;
    } chk_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // reset and clr have the same effect everywhere
    logic        flush;
    chk_t        s1_dat;
    logic        s1_vld;
    logic [31:0] exp_res;
    logic        exp_zero;
    logic        mismatch;

    assign flush = reset | clr;

    // Stage 1: capture the strobe; data holds while idle, a flush drops whatever is sampled
    always_ff @(posedge clk) begin
        if (flush) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
        end else begin
            s1_vld <= chk_valid;
            if (chk_valid) begin
                s1_dat <= '{a: a, b: b, sel: sel, res: res, zero: zero};
            end
        end
    end

    // Golden model on the registered operands
    always_comb begin
        exp_res = '0;
        case (s1_dat.sel)
            3'b000:  exp_res = s1_dat.a & s1_dat.b;
            3'b001:  exp_res = s1_dat.a | s1_dat.b;
            3'b010:  exp_res = s1_dat.a + s1_dat.b;
            3'b011:  exp_res = s1_dat.a ^ s1_dat.b;
            3'b100:  exp_res = s1_dat.a - s1_dat.b;
            3'b101:  exp_res = {31'd0, ($signed(s1_dat.a) < $signed(s1_dat.b))};
            3'b110:  exp_res = ~(s1_dat.a | s1_dat.b);
            default: exp_res = {31'd0, (s1_dat.a < s1_dat.b)};
        endcase
    end

    // A wrong zero flag alone is enough to fail the check
    always_comb begin
        exp_zero = (exp_res == 32'd0);
        mismatch = (s1_dat.res != exp_res) || (s1_dat.zero != exp_zero);
    end

    // Stage 2: score, count with saturation, capture the first mismatch only
    always_ff @(posedge clk) begin
        if (flush) begin
            chk_done <= 1'b0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            err      <= 1'b0;
            ff_sel   <= '0;
            ff_a     <= '0;
            ff_b     <= '0;
            ff_res   <= '0;
            ff_exp   <= '0;
        end else begin
            chk_done <= s1_vld;
            if (s1_vld) begin
                if (mismatch) begin
                    if (fail_cnt != CNT_MAX) begin
                        fail_cnt <= fail_cnt + CNT_ONE;
                    end
                    if (!err) begin
                        err    <= 1'b1;
                        ff_sel <= s1_dat.sel;
                        ff_a   <= s1_dat.a;
                        ff_b   <= s1_dat.b;
                        ff_res <= s1_dat.res;
                        ff_exp <= exp_res;
                    end
                end else if (pass_cnt != CNT_MAX) begin
                    pass_cnt <= pass_cnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_result_checker.sv
module tb_alu_result_checker;

    logic        clk = 1'b0;
    logic        reset, clr, reset4;
    logic        chk_valid;
    logic [31:0] a, b, res;
    logic [2:0]  sel;
    logic        zero;

    logic [15:0] pass_cnt, fail_cnt;
    logic        err, chk_done;
    logic [2:0]  ff_sel;
    logic [31:0] ff_a, ff_b, ff_res, ff_exp;

    logic [3:0]  pass_cnt4, fail_cnt4;
    logic        err4, chk_done4;
    logic [2:0]  ff_sel4;
    logic [31:0] ff_a4, ff_b4, ff_res4, ff_exp4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_result_checker #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .clr(clr), .chk_valid(chk_valid),
        .a(a), .b(b), .sel(sel), .res(res), .zero(zero),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err(err), .chk_done(chk_done),
        .ff_sel(ff_sel), .ff_a(ff_a), .ff_b(ff_b), .ff_res(ff_res), .ff_exp(ff_exp)
    );

    alu_result_checker #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset4), .clr(1'b0), .chk_valid(chk_valid),
        .a(a), .b(b), .sel(sel), .res(res), .zero(zero),
        .pass_cnt(pass_cnt4), .fail_cnt(fail_cnt4), .err(err4), .chk_done(chk_done4),
        .ff_sel(ff_sel4), .ff_a(ff_a4), .ff_b(ff_b4), .ff_res(ff_res4), .ff_exp(ff_exp4)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  sel;
        logic [31:0] res;
        logic        zero;
        logic [31:0] exp;   // hand-computed golden result
        logic        pass;  // hand-judged outcome
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Advance one edge; outputs are then stable for sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ta, input logic [31:0] tb_,
                         input logic [2:0] ts, input logic [31:0] tr, input logic tz);
        chk_valid = v; a = ta; b = tb_; sel = ts; res = tr; zero = tz;
    endtask

    initial begin
        int ep, ef, first;
        logic eerr;

        vecs[0]  = '{32'd8, 32'd4, 3'b010, 32'd12, 1'b0, 32'd12, 1'b1};
        vecs[1]  = '{32'd8, 32'd4, 3'b100, 32'd4, 1'b0, 32'd4, 1'b1};
        vecs[2]  = '{32'd8, 32'd4, 3'b000, 32'd0, 1'b1, 32'd0, 1'b1};
        vecs[3]  = '{32'd0, 32'd0, 3'b100, 32'd0, 1'b0, 32'd0, 1'b0};          // bad zero flag
        vecs[4]  = '{32'd8, 32'd4, 3'b001, 32'd13, 1'b0, 32'd12, 1'b0};
        vecs[5]  = '{32'd8, 32'd4, 3'b011, 32'd0, 1'b1, 32'd12, 1'b0};
        vecs[6]  = '{32'hFFFF_FFFF, 32'd1, 3'b101, 32'd1, 1'b0, 32'd1, 1'b1};  // -1 < 1 signed
        vecs[7]  = '{32'hFFFF_FFFF, 32'd1, 3'b111, 32'd0, 1'b1, 32'd0, 1'b1};  // unsigned: not less
        vecs[8]  = '{32'hFFFF_FFFF, 32'd1, 3'b010, 32'd0, 1'b1, 32'd0, 1'b1};  // wrap-around
        vecs[9]  = '{32'd5, 32'd3, 3'b110, 32'hFFFF_FFF8, 1'b0, 32'hFFFF_FFF8, 1'b1};
        vecs[10] = '{32'h8000_0000, 32'd1, 3'b111, 32'd0, 1'b1, 32'd0, 1'b1};
        vecs[11] = '{32'h8000_0000, 32'd1, 3'b101, 32'd1, 1'b0, 32'd1, 1'b1};

        reset = 1'b1; reset4 = 1'b1; clr = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 3'd0, 32'd0, 1'b0);
        step(); step();
        check("rst_pass_cnt", 32'(pass_cnt), 32'd0);
        check("rst_fail_cnt", 32'(fail_cnt), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_chk_done", 32'(chk_done), 32'd0);
        check("rst_ff", {ff_a | ff_b | ff_res | ff_exp | 32'(ff_sel)}, 32'd0);
        reset = 1'b0;

        // Table: one strobe, one idle edge per vector
        ep = 0; ef = 0; eerr = 1'b0; first = -1;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].res, vecs[i].zero);
            step();
            check($sformatf("v%0d_done_capture_edge", i), 32'(chk_done), 32'd0);
            drive(1'b0, 32'd0, 32'd0, 3'd0, 32'd0, 1'b0);
            step();
            if (vecs[i].pass) ep++;
            else begin
                ef++;
                if (first < 0) first = i;
                eerr = 1'b1;
            end
            check($sformatf("v%0d_done", i), 32'(chk_done), 32'd1);
            check($sformatf("v%0d_pass_cnt", i), 32'(pass_cnt), 32'(ep));
            check($sformatf("v%0d_fail_cnt", i), 32'(fail_cnt), 32'(ef));
            check($sformatf("v%0d_err", i), 32'(err), 32'(eerr));
            if (first >= 0) begin
                check($sformatf("v%0d_ff_sel", i), 32'(ff_sel), 32'(vecs[first].sel));
                check($sformatf("v%0d_ff_a", i), ff_a, vecs[first].a);
                check($sformatf("v%0d_ff_b", i), ff_b, vecs[first].b);
                check($sformatf("v%0d_ff_res", i), ff_res, vecs[first].res);
                check($sformatf("v%0d_ff_exp", i), ff_exp, vecs[first].exp);
            end
        end
        step();
        check("idle_done", 32'(chk_done), 32'd0);

        // 20 back-to-back strobes, clr at the edge that samples strobe 11.
        // Strobe 10 (in stage 1) and strobe 11 are discarded; 12..20 count.
        reset = 1'b1; step(); reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            drive(1'b1, 32'(k), 32'd1, 3'b010, 32'(k + 1), 1'b0);
            clr = (k == 11);
            step();
            if (k == 10) check("b2b_pass_before_clr", 32'(pass_cnt), 32'd9);
            if (k == 10) check("b2b_done_streaming", 32'(chk_done), 32'd1);
            if (k == 11) check("b2b_pass_at_clr", 32'(pass_cnt), 32'd0);
            if (k == 11) check("b2b_done_at_clr", 32'(chk_done), 32'd0);
            if (k == 12) check("b2b_done_after_clr", 32'(chk_done), 32'd0);
        end
        clr = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 3'd0, 32'd0, 1'b0);
        step();
        check("b2b_final_pass", 32'(pass_cnt), 32'd9);
        check("b2b_final_fail", 32'(fail_cnt), 32'd0);

        // Saturation on the 4-bit instance
        check("sat_rst_pass", 32'(pass_cnt4), 32'd0);
        reset4 = 1'b0;
        for (int k = 0; k < 17; k++) begin
            drive(1'b1, 32'(k), 32'(k), 3'b011, 32'd0, 1'b1);
            step();
        end
        drive(1'b0, 32'd0, 32'd0, 3'd0, 32'd0, 1'b0);
        step();
        check("sat_pass_cnt", 32'(pass_cnt4), 32'd15);
        check("sat_fail_cnt", 32'(fail_cnt4), 32'd0);
        check("sat_err", 32'(err4), 32'd0);
        reset4 = 1'b1;

        // Reset mid-stream with a mismatch in stage 1 and another sampled at the reset edge
        reset = 1'b1; step(); reset = 1'b0;
        drive(1'b1, 32'd1, 32'd1, 3'b010, 32'd5, 1'b0);
        step();
        reset = 1'b1;
        drive(1'b1, 32'd2, 32'd2, 3'b010, 32'd9, 1'b0);
        step();
        reset = 1'b0;
        // Strobe on the first edge after reset deasserts must be captured
        drive(1'b1, 32'd3, 32'd3, 3'b000, 32'd3, 1'b0);
        step();
        check("mid_rst_fail", 32'(fail_cnt), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_done", 32'(chk_done), 32'd0);
        drive(1'b0, 32'd0, 32'd0, 3'd0, 32'd0, 1'b0);
        step();
        check("post_rst_done", 32'(chk_done), 32'd1);
        check("post_rst_pass", 32'(pass_cnt), 32'd1);
        check("post_rst_fail", 32'(fail_cnt), 32'd0);
        check("post_rst_err", 32'(err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
